fadd_stage2_pipe: RTL and testbench
===================================

// Module: fadd_stage2_pipe
// PURPOSE
//  Second stage of the 3-step FP add pipeline. Consumes the aligned operands from stage 1
//  (shifted/unshifted fraction, signs, max exponent) and performs the signed magnitude
//  add/subtract. Registers the result for stage 3 (normalize/round) behind a valid/ready
//  handshake, with a 2-entry skid buffer for full throughput under backpressure.
// PARAMETERS
//  FRAC_W  26  aligned fraction width {hidden,23 frac,2 guard}
//  EXP_W   8   exponent width
//  CNT_W   16  stall counter width (FADD_S2_STALL_CNT_EN only)
// PORTS
//  CLK               in   1        clock
//  nRST              in   1        asynchronous active-low reset
//  flush             in   1        sync flush: drop all held entries
//  in_valid          in   1        stage-1 operands valid
//  in_ready          out  1        stage accepts operands this cycle
//  sign_shifted      in   1        sign of the aligned (shifted) operand
//  frac_shifted      in   FRAC_W   aligned fraction of smaller-exponent operand
//  sign_not_shifted  in   1        sign of the larger-exponent operand
//  frac_not_shifted  in   FRAC_W   fraction of the larger-exponent operand
//  exp_max           in   EXP_W    larger exponent
//  out_valid         out  1        result valid to stage 3
//  out_ready         in   1        stage 3 accepts result
//  sign_out          out  1        result sign
//  sum_out           out  FRAC_W+1 magnitude; MSB is the carry-out
//  exp_out           out  EXP_W    exp_max passed through
//  stall_cnt         out  CNT_W    (FADD_S2_STALL_CNT_EN only) backpressure cycles
// BEHAVIOUR
//  - Reset (nRST=0, async): state EMPTY, out_valid=0, sign_out/sum_out/exp_out=0,
//    stall_cnt=0; in_ready=1 after reset release.
//  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - Arithmetic (combinational on input, registered on capture), a=not_shifted, b=shifted:
//    signs equal: sum={0,a}+{0,b}, sign=sign_not_shifted.
//    signs differ, a>b: sum=a-b, sign=sign_not_shifted; a<b: sum=b-a, sign=sign_shifted.
//    signs differ, a==b: sum=0, sign=0 (+0, RNE).
//    Subtract result MSB always 0. exp_out=exp_max unchanged.
//  - Latency 1 cycle (capture edge -> out_valid); throughput 1 result/cycle.
//  - States (main reg M drives outputs, skid reg S): in_ready = (state != FULL).
//    EMPTY: in_fire -> M<=new, ONE.
//    ONE:   in_fire & out_fire -> M<=new, ONE; in_fire & !out_fire -> S<=new, FULL;
//           !in_fire & out_fire -> EMPTY; else hold.
//    FULL:  out_fire -> M<=S, ONE; else hold. No input accepted.
//  - Ordering strictly FIFO; M/S never overwritten while held and not consumed.
//  - out_valid=1 exactly in ONE/FULL; outputs stable while out_valid & !out_ready.
//  - flush=1: next state EMPTY, out_valid=0 next cycle, concurrent in_fire discarded;
//    flush has priority over all transitions. Data regs may keep stale values.
//  - Reset mid-operation discards all held entries immediately.
// CONFIGURATION
//  FADD_S2_STALL_CNT_EN defined: stall_cnt port present; increments each cycle with
//  out_valid & !out_ready, saturates at all-ones, cleared by reset only (not flush).
//  Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1) 1.0+1.0: a=b=26'h2000000, signs 0, exp_max=8'd127 -> next cycle out_valid=1,
//     sum_out=27'h4000000, sign_out=0, exp_out=127.
//  2) a=26'h2000000 s0, b=26'h1000000 s1 -> sum_out=27'h1000000, sign_out=0;
//     a=26'h2000000 s0, b=26'h3000000 s1 -> sum_out=27'h1000000, sign_out=1.
//  3) Cancel: a=b=26'h2800000, signs 0/1 -> sum_out=0, sign_out=0.
//  4) Backpressure: out_ready=0, 3 back-to-back inputs -> 2 accepted, in_ready=0 from
//     2nd capture; out_ready=1 -> results drain in order, 1 per cycle; stall_cnt counts.
//  5) Streaming: in_valid=out_ready=1 for 8 cycles -> 8 results, no bubbles, in_ready=1.
//  6) Flush in FULL with in_valid=1 -> out_valid=0 next cycle, in_ready=1, nothing out;
//     nRST pulse mid-stream -> out_valid=0 immediately, stall_cnt=0.

Source files
------------

// File: rtl/fadd_stage2_pipe.sv
// FP add stage 2: signed-magnitude add/subtract of aligned fractions, registered
// behind a valid/ready handshake with a 2-entry skid buffer. Optional macro: FADD_S2_STALL_CNT_EN.
module fadd_stage2_pipe #(
  parameter int unsigned FRAC_W = 26,
  parameter int unsigned EXP_W  = 8
`ifdef FADD_S2_STALL_CNT_EN
  ,
  parameter int unsigned CNT_W  = 16
`endif
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                sign_shifted,
  input  logic [FRAC_W-1:0]   frac_shifted,
  input  logic                sign_not_shifted,
  input  logic [FRAC_W-1:0]   frac_not_shifted,
  input  logic [EXP_W-1:0]    exp_max,
`ifdef FADD_S2_STALL_CNT_EN
  output logic [CNT_W-1:0]    stall_cnt,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic                sign_out,
  output logic [FRAC_W:0]     sum_out,
  output logic [EXP_W-1:0]    exp_out
);

  localparam int unsigned SUM_W = FRAC_W + 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic               load_m_new, load_m_skid, load_s;
  logic               in_fire, out_fire;

  logic               m_sign_q, s_sign_q;
  logic [SUM_W-1:0]   m_sum_q, s_sum_q;
  logic [EXP_W-1:0]   m_exp_q, s_exp_q;

  logic               calc_sign_c;
  logic [SUM_W-1:0]   calc_sum_c;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  // Signed-magnitude add: a = larger-exponent operand, b = aligned operand.
  always_comb begin
    calc_sign_c = 1'b0;
    calc_sum_c  = '0;
    if (sign_not_shifted == sign_shifted) begin
      calc_sum_c  = {1'b0, frac_not_shifted} + {1'b0, frac_shifted};
      calc_sign_c = sign_not_shifted;
    end else if (frac_not_shifted > frac_shifted) begin
      calc_sum_c  = {1'b0, FRAC_W'(frac_not_shifted - frac_shifted)};
      calc_sign_c = sign_not_shifted;
    end else if (frac_not_shifted < frac_shifted) begin
      calc_sum_c  = {1'b0, FRAC_W'(frac_shifted - frac_not_shifted)};
      calc_sign_c = sign_shifted;
    end
  end

  // Next-state and register-load decode; flush overrides every transition.
  always_comb begin
    state_d     = state_q;
    load_m_new  = 1'b0;
    load_m_skid = 1'b0;
    load_s      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            load_m_new = 1'b1;
            state_d    = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            load_m_new = 1'b1;
          end else if (in_fire) begin
            load_s  = 1'b1;
            state_d = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            load_m_skid = 1'b1;
            state_d     = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != FULL);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Main (output) and skid data registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_sign_q <= 1'b0;
      m_sum_q  <= '0;
      m_exp_q  <= '0;
      s_sign_q <= 1'b0;
      s_sum_q  <= '0;
      s_exp_q  <= '0;
    end else begin
      if (load_m_new) begin
        m_sign_q <= calc_sign_c;
        m_sum_q  <= calc_sum_c;
        m_exp_q  <= exp_max;
      end else if (load_m_skid) begin
        m_sign_q <= s_sign_q;
        m_sum_q  <= s_sum_q;
        m_exp_q  <= s_exp_q;
      end
      if (load_s) begin
        s_sign_q <= calc_sign_c;
        s_sum_q  <= calc_sum_c;
        s_exp_q  <= exp_max;
      end
    end
  end

`ifdef FADD_S2_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating backpressure counter; only reset clears it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_q && !out_ready && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sign_out  = m_sign_q;
  assign sum_out   = m_sum_q;
  assign exp_out   = m_exp_q;

endmodule

// File: tb/tb_fadd_stage2_pipe.sv
// Directed bench for fadd_stage2_pipe: arithmetic vector table plus handshake sequences.
module tb_fadd_stage2_pipe;

  localparam int unsigned FRAC_W = 26;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned CNT_W  = 16;

  logic               CLK = 1'b0;
  logic               nRST;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic               sign_shifted;
  logic [FRAC_W-1:0]  frac_shifted;
  logic               sign_not_shifted;
  logic [FRAC_W-1:0]  frac_not_shifted;
  logic [EXP_W-1:0]   exp_max;
  logic               out_valid;
  logic               out_ready;
  logic               sign_out;
  logic [FRAC_W:0]    sum_out;
  logic [EXP_W-1:0]   exp_out;
`ifdef FADD_S2_STALL_CNT_EN
  logic [CNT_W-1:0]   stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  fadd_stage2_pipe dut (
    .CLK              (CLK),
    .nRST             (nRST),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .sign_shifted     (sign_shifted),
    .frac_shifted     (frac_shifted),
    .sign_not_shifted (sign_not_shifted),
    .frac_not_shifted (frac_not_shifted),
    .exp_max          (exp_max),
`ifdef FADD_S2_STALL_CNT_EN
    .stall_cnt        (stall_cnt),
`endif
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .sign_out         (sign_out),
    .sum_out          (sum_out),
    .exp_out          (exp_out)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic              sn;
    logic [FRAC_W-1:0] a;
    logic              ss;
    logic [FRAC_W-1:0] b;
    logic [EXP_W-1:0]  e;
    logic [FRAC_W:0]   exp_sum;
    logic              exp_sign;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic sn, input logic [FRAC_W-1:0] a,
                       input logic ss, input logic [FRAC_W-1:0] b,
                       input logic [EXP_W-1:0] e);
    sign_not_shifted = sn;
    frac_not_shifted = a;
    sign_shifted     = ss;
    frac_shifted     = b;
    exp_max          = e;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
  endtask

  initial begin
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, '0, 1'b0, '0, '0);

    vecs[0] = '{1'b0, 26'h2000000, 1'b0, 26'h2000000, 8'd127, 27'h4000000, 1'b0};
    vecs[1] = '{1'b0, 26'h2000000, 1'b1, 26'h1000000, 8'd10,  27'h1000000, 1'b0};
    vecs[2] = '{1'b0, 26'h2000000, 1'b1, 26'h3000000, 8'd20,  27'h1000000, 1'b1};
    vecs[3] = '{1'b0, 26'h2800000, 1'b1, 26'h2800000, 8'd30,  27'h0000000, 1'b0};
    vecs[4] = '{1'b1, 26'h2800000, 1'b0, 26'h2800000, 8'd40,  27'h0000000, 1'b0};
    vecs[5] = '{1'b1, 26'h3FFFFFF, 1'b1, 26'h3FFFFFF, 8'd255, 27'h7FFFFFE, 1'b1};
    vecs[6] = '{1'b1, 26'h0000001, 1'b0, 26'h0000000, 8'd1,   27'h0000001, 1'b1};
    vecs[7] = '{1'b1, 26'h1000000, 1'b0, 26'h2FFFFFF, 8'd0,   27'h1FFFFFF, 1'b0};

    do_reset();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_sum",       32'(sum_out),   32'd0);
    chk("rst_sign",      32'(sign_out),  32'd0);
    chk("rst_exp",       32'(exp_out),   32'd0);
`ifdef FADD_S2_STALL_CNT_EN
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif

    // Arithmetic vectors: one capture, check, then drain.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].sn, vecs[i].a, vecs[i].ss, vecs[i].b, vecs[i].e);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d_sum", i),   32'(sum_out),   32'(vecs[i].exp_sum));
      chk($sformatf("vec%0d_sign", i),  32'(sign_out),  32'(vecs[i].exp_sign));
      chk($sformatf("vec%0d_exp", i),   32'(exp_out),   32'(vecs[i].e));
      step();
      chk($sformatf("vec%0d_drain", i), 32'(out_valid), 32'd0);
    end

    // Backpressure: three offered, two accepted, drained in order.
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(1'b0, 26'd100, 1'b0, 26'd0, 8'd1);
    step();
    chk("bp_cap1_valid", 32'(out_valid), 32'd1);
    chk("bp_cap1_ready", 32'(in_ready),  32'd1);
    drive(1'b0, 26'd200, 1'b0, 26'd0, 8'd2);
    step();
    chk("bp_cap2_ready", 32'(in_ready),  32'd0);
    chk("bp_cap2_hold",  32'(sum_out),   32'd100);
    drive(1'b0, 26'd300, 1'b0, 26'd0, 8'd3);
    step();
    chk("bp_3rd_ready",  32'(in_ready),  32'd0);
    chk("bp_3rd_hold",   32'(sum_out),   32'd100);
    chk("bp_3rd_exp",    32'(exp_out),   32'd1);
`ifdef FADD_S2_STALL_CNT_EN
    chk("bp_stall_cnt",  32'(stall_cnt), 32'd2);
`endif
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_drain1_valid", 32'(out_valid), 32'd1);
    chk("bp_drain1_sum",   32'(sum_out),   32'd200);
    chk("bp_drain1_exp",   32'(exp_out),   32'd2);
    chk("bp_drain1_ready", 32'(in_ready),  32'd1);
    step();
    chk("bp_drain2_valid", 32'(out_valid), 32'd0);
`ifdef FADD_S2_STALL_CNT_EN
    chk("bp_stall_final",  32'(stall_cnt), 32'd2);
`endif

    // Streaming: one result per cycle, never stalling input.
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 26'(i * 3 + 5), 1'b0, 26'(i), 8'(i + 50));
      step();
      chk($sformatf("str%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("str%0d_sum", i),   32'(sum_out),   32'(i * 4 + 5));
      chk($sformatf("str%0d_exp", i),   32'(exp_out),   32'(i + 50));
      chk($sformatf("str%0d_ready", i), 32'(in_ready),  32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("str_end_valid", 32'(out_valid), 32'd0);

    // Flush while FULL with a concurrent input: everything dropped.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(1'b0, 26'd7, 1'b0, 26'd0, 8'd7);
    step();
    drive(1'b0, 26'd8, 1'b0, 26'd0, 8'd8);
    step();
    chk("fl_full_ready", 32'(in_ready), 32'd0);
    flush = 1'b1;
    drive(1'b0, 26'd9, 1'b0, 26'd0, 8'd9);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_ready", 32'(in_ready),  32'd1);
    out_ready = 1'b1;
    step();
    chk("fl_nothing_out", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(1'b0, 26'd11, 1'b0, 26'd0, 8'd11);
    step();
    step();
    step();
    chk("rm_pre_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    #2 nRST = 1'b0;
    #1;
    chk("rm_valid_async", 32'(out_valid), 32'd0);
    chk("rm_ready_async", 32'(in_ready),  32'd1);
`ifdef FADD_S2_STALL_CNT_EN
    chk("rm_stall_cnt",   32'(stall_cnt), 32'd0);
`endif
    step();
    nRST      = 1'b1;
    out_ready = 1'b1;
    step();
    chk("rm_after_valid", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
